fifo_queue: RTL and testbench

- Synchronous single-clock FIFO with first-word-fall-through output: the head entry is always presented on data_out while the queue is non-empty.
- Used as the read-tag and read-data queues of the Avalon memory wrapper, and as a general buffering primitive.
- Reports empty, full and occupancy.

---
 rtl/fifo_queue_if.sv | 34 +++
 rtl/fifo_queue.sv | 146 ++++++++++++++
 tb/tb_fifo_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_queue_if.sv
// fifo_queue_if - handshake bundle for fifo_queue.
//
// Parameters:
//   DATAW - entry width in bits
//   SIZE  - queue depth in entries (sets the width of size)
//
// Signals:
//   push, pop, data_in        - driven by the producer/consumer (master)
//   data_out, empty, full,
//   size                      - driven by the queue (slave)
interface fifo_queue_if #(
  parameter int DATAW = 1,
  parameter int SIZE  = 2
);
  localparam int SIZEW = $clog2(SIZE + 1);

  logic             push;
  logic             pop;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             empty;
  logic             full;
  logic [SIZEW-1:0] size;

  modport master (
    output push, pop, data_in,
    input  data_out, empty, full, size
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, empty, full, size
  );
endinterface

// File: rtl/fifo_queue.sv
// fifo_queue - single-clock first-word-fall-through FIFO.
//
// The head entry is presented on q.data_out whenever the queue is non-empty.
// Every output is registered state or a decode of it; push/pop/data_in never
// reach an output combinationally.
//
// Parameters:
//   DATAW    - entry width in bits (>=1)
//   SIZE     - depth in entries (>=1, any value, not just powers of two)
//   BUFFERED - 1: data_out comes straight from a head flop; 0: from the read mux
//   FASTRAM  - 1: storage tagged for distributed RAM; no functional effect
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous, active-low reset
//   q     - fifo_queue_if slave modport (push, pop, data_in, data_out,
//           empty, full, size)
module fifo_queue #(
  parameter int DATAW    = 1,
  parameter int SIZE     = 2,
  parameter int BUFFERED = 0,
  parameter int FASTRAM  = 0
) (
  input  logic         clk,
  input  logic         reset,
  fifo_queue_if.slave  q
);

  localparam int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int SIZEW = $clog2(SIZE + 1);

  logic [ADDRW-1:0] rd_ptr;
  logic [ADDRW-1:0] wr_ptr;
  logic [SIZEW-1:0] count;
  logic             is_empty;
  logic             is_full;
  logic             push_ok;
  logic             pop_ok;
  logic [ADDRW-1:0] rd_next;
  logic [ADDRW-1:0] wr_next;
  logic [ADDRW-1:0] rd_new;
  logic [ADDRW-1:0] rd_addr;
  logic [DATAW-1:0] rd_data;

  // Explicit wrap so non-power-of-two depths never index past SIZE-1.
  function automatic logic [ADDRW-1:0] next_ptr(input logic [ADDRW-1:0] ptr);
    if (ptr == ADDRW'(SIZE - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + ADDRW'(1);
    end
  endfunction

  assign is_empty = (count == '0);
  assign is_full  = (count == SIZEW'(SIZE));

  // A push into a full queue is still taken when the head leaves the same
  // cycle; a pop on an empty queue is dropped even if a push arrives with it.
  assign push_ok = q.push && (!is_full || q.pop);
  assign pop_ok  = q.pop && !is_empty;

  assign rd_next = next_ptr(rd_ptr);
  assign wr_next = next_ptr(wr_ptr);
  assign rd_new  = pop_ok ? rd_next : rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      if (push_ok) begin
        wr_ptr <= wr_next;
      end
      if (push_ok && !pop_ok) begin
        count <= count + SIZEW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - SIZEW'(1);
      end
    end
  end

  // The buffered variant looks one step ahead: it reads the entry that will
  // be the head after this edge so the head flop can be loaded in time.
  assign rd_addr = (BUFFERED != 0) ? rd_new : rd_ptr;

  // Storage is never reset; an entry is only read after it has been written.
  if (FASTRAM != 0) begin : g_lutram
    (* ram_style = "distributed" *) logic [DATAW-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= q.data_in;
      end
    end

    assign rd_data = mem[rd_addr];
  end else begin : g_regs
    logic [DATAW-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= q.data_in;
      end
    end

    assign rd_data = mem[rd_addr];
  end

  if (BUFFERED != 0) begin : g_head
    logic [DATAW-1:0] head;

    // When the incoming entry lands exactly where the next head will be
    // (queue empty, or draining to one entry while pushing) it bypasses
    // storage, so there is no bubble.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        head <= '0;
      end else if (push_ok || pop_ok) begin
        head <= (push_ok && (rd_new == wr_ptr)) ? q.data_in : rd_data;
      end
    end

    assign q.data_out = head;
  end else begin : g_mux
    assign q.data_out = rd_data;
  end

  assign q.empty = is_empty;
  assign q.full  = is_full;
  assign q.size  = count;

  // Misuse is ignored by the logic above but flagged in simulation.
  always @(posedge clk) begin
    if (reset) begin
      overflow_check: assert (!(q.push && is_full && !q.pop))
        else $warning("fifo_queue: push while full ignored");
      underflow_check: assert (!(q.pop && is_empty && !q.push))
        else $warning("fifo_queue: pop while empty ignored");
    end
  end

endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue - self-checking bench for fifo_queue.
//
// Six queues share one stimulus stream: SIZE 4, 3 and 1, each in unbuffered
// and buffered form. The SIZE=4 pair is checked against a scoreboard queue;
// the smaller ones are checked on the scenarios where their behaviour is
// known from the stimulus alone.
module tb_fifo_queue;

  localparam int NDUT  = 6;
  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       push    = 1'b0;
  logic       pop     = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout [NDUT];
  logic       emp  [NDUT];
  logic       ful  [NDUT];
  logic [2:0] sz   [NDUT];

  int depth_of [NDUT] = '{4, 4, 3, 3, 1, 1};

  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;

  // Clock generation: 10 time-unit period
  always #5 clk = ~clk;

  // Instances: even index unbuffered, odd index buffered
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int SZ  = (g < 2) ? 4 : ((g < 4) ? 3 : 1);
    localparam int BUF = g % 2;

    fifo_queue_if #(.DATAW(8), .SIZE(SZ)) bus ();

    assign bus.push    = push;
    assign bus.pop     = pop;
    assign bus.data_in = data_in;

    fifo_queue #(
      .DATAW    (8),
      .SIZE     (SZ),
      .BUFFERED (BUF),
      .FASTRAM  (BUF)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (bus)
    );

    assign dout[g] = bus.data_out;
    assign emp[g]  = bus.empty;
    assign ful[g]  = bus.full;
    assign sz[g]   = 3'(bus.size);
  end

  // Drives one clock of stimulus and advances the scoreboard by the
  // acceptance rules of a DEPTH-entry queue; returns at posedge+1.
  task automatic drive_cycle(input logic p, input logic q, input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    push    = p;
    pop     = q;
    data_in = d;
    pop_ok  = q && (sb.size() > 0);
    push_ok = p && ((sb.size() < DEPTH) || pop_ok);
    @(posedge clk);
    if (pop_ok) sb.delete(0);
    if (push_ok) sb.push_back(d);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  // Reset held low with random traffic: all queues stay empty
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push    = 1'($urandom_range(0, 1));
      pop     = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (emp[k] !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_empty dut%0d: got %b expected 1", k, emp[k]);
      end
      checks++;
      if (ful[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_full dut%0d: got %b expected 0", k, ful[k]);
      end
      checks++;
      if (sz[k] !== 3'd0) begin
        errors++; $display("[TB] FAIL reset_size dut%0d: got %0d expected 0", k, sz[k]);
      end
      if (k % 2 == 1) begin
        checks++;
        if (dout[k] !== 8'h00) begin
          errors++; $display("[TB] FAIL reset_dout dut%0d: got %h expected 00", k, dout[k]);
        end
      end
    end
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    sb.delete();
  endtask

  // Fill to full, then one push past full that must be dropped
  task automatic test_fill();
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, vals[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (sz[k] !== 3'(sb.size())) begin
          errors++; $display("[TB] FAIL fill_size%0d dut%0d: got %0d expected %0d", i, k, sz[k], sb.size());
        end
        checks++;
        if (ful[k] !== (sb.size() == DEPTH)) begin
          errors++; $display("[TB] FAIL fill_full%0d dut%0d: got %b expected %b", i, k, ful[k], sb.size() == DEPTH);
        end
        checks++;
        if (dout[k] !== sb[0]) begin
          errors++; $display("[TB] FAIL fill_head%0d dut%0d: got %h expected %h", i, k, dout[k], sb[0]);
        end
      end
    end
  endtask

  // Drain from full in order, then one pop on empty that must be dropped
  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (sb.size() > 0) begin
          checks++;
          if (dout[k] !== sb[0]) begin
            errors++; $display("[TB] FAIL drain_head%0d dut%0d: got %h expected %h", i, k, dout[k], sb[0]);
          end
        end
      end
      drive_cycle(1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (sz[k] !== 3'(sb.size())) begin
          errors++; $display("[TB] FAIL drain_size%0d dut%0d: got %0d expected %0d", i, k, sz[k], sb.size());
        end
        checks++;
        if (emp[k] !== (sb.size() == 0)) begin
          errors++; $display("[TB] FAIL drain_empty%0d dut%0d: got %b expected %b", i, k, emp[k], sb.size() == 0);
        end
      end
    end
  endtask

  // Two entries queued, then simultaneous push+pop so the pointers wrap
  task automatic test_back_to_back();
    drive_cycle(1'b1, 1'b0, 8'h01);
    drive_cycle(1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dout[k] !== sb[0]) begin
          errors++; $display("[TB] FAIL b2b_head%0d dut%0d: got %h expected %h", i, k, dout[k], sb[0]);
        end
      end
      if (i < 10) begin
        drive_cycle(1'b1, 1'b1, 8'hA0 + 8'(i));
      end else begin
        drive_cycle(1'b0, 1'b1, 8'h00);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (sz[k] !== 3'(sb.size())) begin
          errors++; $display("[TB] FAIL b2b_size%0d dut%0d: got %0d expected %0d", i, k, sz[k], sb.size());
        end
      end
    end
  endtask

  // Push+pop on an empty queue, across every depth and buffering choice
  task automatic test_push_pop_empty();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    drive_cycle(1'b1, 1'b1, 8'h5A);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (sz[k] !== 3'd1) begin
        errors++; $display("[TB] FAIL pp_size dut%0d: got %0d expected 1", k, sz[k]);
      end
      checks++;
      if (emp[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL pp_empty dut%0d: got %b expected 0", k, emp[k]);
      end
      checks++;
      if (ful[k] !== (depth_of[k] == 1)) begin
        errors++; $display("[TB] FAIL pp_full dut%0d: got %b expected %b", k, ful[k], depth_of[k] == 1);
      end
      checks++;
      if (dout[k] !== 8'h5A) begin
        errors++; $display("[TB] FAIL pp_head dut%0d: got %h expected 5a", k, dout[k]);
      end
    end
    drive_cycle(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (emp[k] !== 1'b1 || sz[k] !== 3'd0) begin
        errors++; $display("[TB] FAIL pp_drain dut%0d: got empty=%b size=%0d expected empty=1 size=0", k, emp[k], sz[k]);
      end
    end
  endtask

  // Asynchronous reset between edges discards queued entries immediately
  task automatic test_async_reset();
    drive_cycle(1'b1, 1'b0, 8'h31);
    drive_cycle(1'b1, 1'b0, 8'h32);
    drive_cycle(1'b1, 1'b0, 8'h33);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sz[k] !== 3'd3) begin
        errors++; $display("[TB] FAIL ar_pre_size dut%0d: got %0d expected 3", k, sz[k]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (emp[k] !== 1'b1 || sz[k] !== 3'd0 || ful[k] !== 1'b0) begin
        errors++; $display("[TB] FAIL ar_flags dut%0d: got empty=%b full=%b size=%0d expected 1 0 0", k, emp[k], ful[k], sz[k]);
      end
      if (k % 2 == 1) begin
        checks++;
        if (dout[k] !== 8'h00) begin
          errors++; $display("[TB] FAIL ar_dout dut%0d: got %h expected 00", k, dout[k]);
        end
      end
    end
    #1;
    reset = 1'b1;
    sb.delete();
    drive_cycle(1'b1, 1'b0, 8'h77);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (dout[k] !== 8'h77 || sz[k] !== 3'd1) begin
        errors++; $display("[TB] FAIL ar_push dut%0d: got data=%h size=%0d expected 77 1", k, dout[k], sz[k]);
      end
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_push_pop_empty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
